mesh_router: RTL and testbench

Parametrised five-port (N/E/S/W/L) mesh router with per-input flit FIFOs, dimension-ordered XY routing, per-output round-robin arbitration and a registered valid/ready output stage. It is one tile of the 2D NoC mesh. Neighbouring routers connect output-to-input. The local port attaches to the tile's network interface.

---
 rtl/mesh_router_pkg.sv | 28 ++
 rtl/mesh_router_if.sv | 17 +
 rtl/mesh_router_in_fifo.sv | 54 +++++
 rtl/mesh_router.sv | 108 ++++++++++
 tb/tb_mesh_router.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mesh_router_pkg.sv
// mesh_router_pkg: shared port enumeration, default sizes, flit layout and round-robin helper
package mesh_router_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MESH_SIDE  = 4;
    localparam int DEF_CW         = $clog2(DEF_MESH_SIDE);
    localparam int NUM_PORTS      = 5;

    typedef enum logic [2:0] {
        NORTH = 3'd0,
        EAST  = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        LOCAL = 3'd4
    } port_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_CW-1:0]         dest_x;
        logic [DEF_CW-1:0]         dest_y;
    } flit_t;

    // next round-robin start position after granting port g (explicit 4 -> 0 wrap)
    function automatic logic [2:0] rr_next(input logic [2:0] g);
        return (g == 3'd4) ? 3'd0 : g + 3'd1;
    endfunction

endpackage

// File: rtl/mesh_router_if.sv
// mesh_router_if: five-lane valid/ready flit bundle; master drives flits, slave returns ready
interface mesh_router_if #(
    parameter int DW = 32,
    parameter int CW = 2
);
    import mesh_router_pkg::*;

    logic [NUM_PORTS-1:0]         valid;
    logic [NUM_PORTS-1:0]         ready;
    logic [NUM_PORTS-1:0][DW-1:0] data;
    logic [NUM_PORTS-1:0][CW-1:0] dest_x;
    logic [NUM_PORTS-1:0][CW-1:0] dest_y;

    modport master (output valid, data, dest_x, dest_y, input ready);
    modport slave  (input valid, data, dest_x, dest_y, output ready);

endinterface

// File: rtl/mesh_router_in_fifo.sv
// router_in_fifo: per-input flit FIFO; a flit pushed into an empty FIFO becomes eligible one cycle later
module router_in_fifo
    import mesh_router_pkg::*;
#(
    parameter type T          = flit_t,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic full,
    output logic avail
);

    localparam int AW = $clog2(FIFO_DEPTH);

    T              mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          fresh;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign avail   = count > {{AW{1'b0}}, fresh};
    assign do_push = push && !full;
    assign do_pop  = pop && avail;
    assign head    = mem[rd_ptr];

    // pointers, occupancy and the just-pushed marker that hides a brand-new head for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            fresh  <= 1'b0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
            fresh  <= do_push;
        end
    end

    // storage needs no reset: occupancy alone decides what is readable
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mesh_router.sv
// mesh_router: five-port XY mesh router with input FIFOs, round-robin output arbitration and registered outputs
module mesh_router
    import mesh_router_pkg::*;
#(
    parameter int X_COORD    = 0,
    parameter int Y_COORD    = 0,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MESH_SIDE  = DEF_MESH_SIDE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    mesh_router_if.slave  in_if,
    mesh_router_if.master out_if
);

    localparam int CW = $clog2(MESH_SIDE);
    localparam logic [CW-1:0] XC = CW'(X_COORD);
    localparam logic [CW-1:0] YC = CW'(Y_COORD);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [CW-1:0]         dest_x;
        logic [CW-1:0]         dest_y;
    } rflit_t;

    rflit_t               head  [NUM_PORTS];
    port_t                route [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt   [NUM_PORTS];
    logic [NUM_PORTS-1:0] avail;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] pop;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        router_in_fifo #(.T(rflit_t), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_if.valid[i]),
            .pop   (pop[i]),
            .din   ({in_if.data[i], in_if.dest_x[i], in_if.dest_y[i]}),
            .head  (head[i]),
            .full  (full[i]),
            .avail (avail[i])
        );
        assign in_if.ready[i] = !full[i];
        assign route[i] = (head[i].dest_x > XC) ? EAST  :
                          (head[i].dest_x < XC) ? WEST  :
                          (head[i].dest_y > YC) ? NORTH :
                          (head[i].dest_y < YC) ? SOUTH : LOCAL;
    end

    // an input is popped by whichever output granted it (at most one)
    always_comb begin
        pop = '0;
        for (int o = 0; o < NUM_PORTS; o++) pop = pop | gnt[o];
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        logic [2:0] ptr_q;
        logic [2:0] gnt_idx;
        logic [2:0] cand;
        logic [3:0] sum;
        logic       gnt_any;
        logic       free;
        logic       v_q;
        rflit_t     f_q;

        assign free   = !v_q || out_if.ready[o];
        assign gnt[o] = gnt_any ? (NUM_PORTS'(1) << gnt_idx) : '0;

        // round-robin search starting at ptr_q for the first eligible input routed here
        always_comb begin
            gnt_any = 1'b0;
            gnt_idx = ptr_q;
            sum     = '0;
            cand    = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                sum  = {1'b0, ptr_q} + 4'(k);
                cand = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
                if (!gnt_any && free && avail[cand] && route[cand] == port_t'(o)) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end

        // output register loads on grant, empties when free without grant, holds while stalled
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                f_q   <= '0;
                ptr_q <= '0;
            end else if (free) begin
                v_q <= gnt_any;
                if (gnt_any) begin
                    f_q   <= head[gnt_idx];
                    ptr_q <= rr_next(gnt_idx);
                end
            end
        end

        assign out_if.valid[o]  = v_q;
        assign out_if.data[o]   = f_q.data;
        assign out_if.dest_x[o] = f_q.dest_x;
        assign out_if.dest_y[o] = f_q.dest_y;
    end

endmodule

// File: tb/tb_mesh_router.sv
// tb_mesh_router: scoreboard bench for two routers at (1,1) and (2,2) with directed flits
module tb_mesh_router;
    import mesh_router_pkg::*;

    localparam int DW    = 32;
    localparam int CW    = 2;
    localparam int DEPTH = 4;

    typedef struct {
        int          r;
        int          p;
        logic [31:0] d;
        logic [1:0]  x;
        logic [1:0]  y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mesh_router_if #(.DW(DW), .CW(CW)) ia_in ();
    mesh_router_if #(.DW(DW), .CW(CW)) ia_out ();
    mesh_router_if #(.DW(DW), .CW(CW)) ib_in ();
    mesh_router_if #(.DW(DW), .CW(CW)) ib_out ();

    mesh_router #(.X_COORD(1), .Y_COORD(1), .DATA_WIDTH(DW), .MESH_SIDE(4), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .in_if(ia_in), .out_if(ia_out)
    );
    mesh_router #(.X_COORD(2), .Y_COORD(2), .DATA_WIDTH(DW), .MESH_SIDE(4), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .in_if(ib_in), .out_if(ib_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic expect_out(input int r, input int p, input logic [31:0] d, input logic [1:0] x, input logic [1:0] y);
        exp_t e;
        e.r = r; e.p = p; e.d = d; e.x = x; e.y = y;
        sb.push_back(e);
    endtask

    task automatic drive(input int r, input int p, input logic v, input logic [31:0] d, input logic [1:0] x, input logic [1:0] y);
        if (r == 0) begin
            ia_in.valid[p] = v; ia_in.data[p] = d; ia_in.dest_x[p] = x; ia_in.dest_y[p] = y;
        end else begin
            ib_in.valid[p] = v; ib_in.data[p] = d; ib_in.dest_x[p] = x; ib_in.dest_y[p] = y;
        end
    endtask

    function automatic logic in_rdy(input int r, input int p);
        return (r == 0) ? ia_in.ready[p] : ib_in.ready[p];
    endfunction

    // offer one flit (called just after a rising edge), hold until accepted, record its expected exit port
    task automatic send(input int r, input int p, input int op, input logic [31:0] d, input logic [1:0] x, input logic [1:0] y);
        int n = 0;
        drive(r, p, 1'b1, d, x, y);
        expect_out(r, op, d, x, y);
        while (!in_rdy(r, p) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL send_timeout r%0d p%0d: in_ready stayed 0, want 1", r, p);
        end
        @(posedge clk); #1;
        drive(r, p, 1'b0, '0, '0, '0);
    endtask

    // monitor: every output transfer must match the oldest pending flit expected on that router/port
    always @(negedge clk) begin
        int          idx;
        logic        v;
        logic        rd;
        logic [31:0] d;
        logic [1:0]  x;
        logic [1:0]  y;
        if (!rst) begin
            for (int r = 0; r < 2; r++) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    v  = (r == 0) ? ia_out.valid[p]  : ib_out.valid[p];
                    rd = (r == 0) ? ia_out.ready[p]  : ib_out.ready[p];
                    d  = (r == 0) ? ia_out.data[p]   : ib_out.data[p];
                    x  = (r == 0) ? ia_out.dest_x[p] : ib_out.dest_x[p];
                    y  = (r == 0) ? ia_out.dest_y[p] : ib_out.dest_y[p];
                    if (v && rd) begin
                        idx = -1;
                        foreach (sb[k]) if (idx < 0 && sb[k].r == r && sb[k].p == p) idx = k;
                        if (idx < 0) begin
                            checks++;
                            failures++;
                            $display("FAIL mon_unexpected r%0d p%0d: got data %0h, want no flit", r, p, d);
                        end else begin
                            chk($sformatf("mon_data r%0d p%0d", r, p), 64'(d), 64'(sb[idx].d));
                            chk($sformatf("mon_dest r%0d p%0d", r, p), 64'({x, y}), 64'({sb[idx].x, sb[idx].y}));
                            sb.delete(idx);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        ia_in.valid = '0; ia_in.data = '0; ia_in.dest_x = '0; ia_in.dest_y = '0;
        ib_in.valid = '0; ib_in.data = '0; ib_in.dest_x = '0; ib_in.dest_y = '0;
        ia_out.ready = '1;
        ib_out.ready = '1;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready_a", 64'(ia_in.ready), 64'h1f);
        chk("rst_in_ready_b", 64'(ib_in.ready), 64'h1f);
        chk("rst_out_valid", 64'({ia_out.valid, ib_out.valid}), 64'h0);
        chk("rst_out_fields", 64'(|{ia_out.data, ia_out.dest_x, ia_out.dest_y, ib_out.data, ib_out.dest_x, ib_out.dest_y}), 64'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // latency: LOCAL flit to (3,1) at router (1,1) leaves EAST two edges after its transfer
        drive(0, 4, 1'b1, 32'hA5, 2'd3, 2'd1);
        expect_out(0, 1, 32'hA5, 2'd3, 2'd1);
        @(posedge clk); #1;
        drive(0, 4, 1'b0, '0, '0, '0);
        chk("lat_t0_valid", 64'(ia_out.valid[1]), 64'h0);
        @(posedge clk); #1;
        chk("lat_t1_valid", 64'(ia_out.valid[1]), 64'h0);
        @(posedge clk); #1;
        chk("lat_t2_out", 64'({ia_out.valid[1], ia_out.data[1]}), 64'({1'b1, 32'hA5}));
        chk("lat_t2_dest", 64'({ia_out.dest_x[1], ia_out.dest_y[1]}), 64'({2'd3, 2'd1}));

        // XY routing at (1,1)
        send(0, 4, 0, 32'h101, 2'd1, 2'd3);
        send(0, 4, 2, 32'h102, 2'd1, 2'd0);
        send(0, 4, 4, 32'h103, 2'd1, 2'd1);
        send(0, 4, 3, 32'h104, 2'd0, 2'd2);
        repeat (6) @(posedge clk); #1;
        chk("routes_drained", 64'(sb.size()), 64'h0);

        // contention at (2,2): N, S, L to (0,2) leave WEST in order N, S, L
        drive(1, 0, 1'b1, 32'h11, 2'd0, 2'd2);
        drive(1, 2, 1'b1, 32'h22, 2'd0, 2'd2);
        drive(1, 4, 1'b1, 32'h33, 2'd0, 2'd2);
        expect_out(1, 3, 32'h11, 2'd0, 2'd2);
        expect_out(1, 3, 32'h22, 2'd0, 2'd2);
        expect_out(1, 3, 32'h33, 2'd0, 2'd2);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, '0, '0, '0);
        drive(1, 2, 1'b0, '0, '0, '0);
        drive(1, 4, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rr1_first", 64'({ib_out.valid[3], ib_out.data[3]}), 64'({1'b1, 32'h11}));
        @(posedge clk); #1;
        chk("rr1_second", 64'({ib_out.valid[3], ib_out.data[3]}), 64'({1'b1, 32'h22}));
        @(posedge clk); #1;
        chk("rr1_third", 64'({ib_out.valid[3], ib_out.data[3]}), 64'({1'b1, 32'h33}));
        @(posedge clk); #1;
        chk("rr1_idle", 64'(ib_out.valid[3]), 64'h0);

        // SOUTH alone moves WEST priority to WEST; then W, N, S contend -> W, N, S
        send(1, 2, 3, 32'h55, 2'd0, 2'd2);
        repeat (4) @(posedge clk); #1;
        drive(1, 0, 1'b1, 32'h61, 2'd0, 2'd2);
        drive(1, 2, 1'b1, 32'h62, 2'd0, 2'd2);
        drive(1, 3, 1'b1, 32'h64, 2'd0, 2'd2);
        expect_out(1, 3, 32'h64, 2'd0, 2'd2);
        expect_out(1, 3, 32'h61, 2'd0, 2'd2);
        expect_out(1, 3, 32'h62, 2'd0, 2'd2);
        @(posedge clk); #1;
        drive(1, 0, 1'b0, '0, '0, '0);
        drive(1, 2, 1'b0, '0, '0, '0);
        drive(1, 3, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rr2_first", 64'(ib_out.data[3]), 64'h64);
        @(posedge clk); #1;
        chk("rr2_second", 64'(ib_out.data[3]), 64'h61);
        @(posedge clk); #1;
        chk("rr2_third", 64'(ib_out.data[3]), 64'h62);

        // backpressure on EAST of (1,1): 1+DEPTH flits accepted, the next one waits
        ia_out.ready[1] = 1'b0;
        for (int i = 0; i < 1 + DEPTH; i++) send(0, 4, 1, 32'hB0 + 32'(i), 2'd3, 2'd1);
        drive(0, 4, 1'b1, 32'hB5, 2'd3, 2'd1);
        expect_out(0, 1, 32'hB5, 2'd3, 2'd1);
        repeat (4) @(posedge clk); #1;
        chk("bp_in_ready", 64'(ia_in.ready[4]), 64'h0);
        chk("bp_out_held", 64'({ia_out.valid[1], ia_out.data[1]}), 64'({1'b1, 32'hB0}));
        repeat (3) @(posedge clk); #1;
        chk("bp_out_stable", 64'({ia_out.valid[1], ia_out.data[1]}), 64'({1'b1, 32'hB0}));

        // full FIFO popping: in_ready stays low that cycle, returns right after the pop edge
        ia_out.ready[1] = 1'b1;
        chk("fullpop_same_cycle", 64'(ia_in.ready[4]), 64'h0);
        @(posedge clk); #1;
        chk("fullpop_next_cycle", 64'(ia_in.ready[4]), 64'h1);
        @(posedge clk); #1;
        drive(0, 4, 1'b0, '0, '0, '0);
        repeat (10) @(posedge clk); #1;
        chk("bp_drained", 64'(sb.size()), 64'h0);

        // reset mid-stream discards buffered and registered flits
        ia_out.ready[0] = 1'b0;
        drive(0, 4, 1'b1, 32'hC0, 2'd1, 2'd3);
        repeat (3) @(posedge clk); #1;
        drive(0, 4, 1'b0, '0, '0, '0);
        chk("mid_pre_valid", 64'(ia_out.valid[0]), 64'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(ia_out.valid), 64'h0);
        chk("mid_rst_fields", 64'(|{ia_out.data, ia_out.dest_x, ia_out.dest_y}), 64'h0);
        chk("mid_rst_ready", 64'(ia_in.ready), 64'h1f);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ia_out.ready[0] = 1'b1;
        repeat (10) @(posedge clk); #1;
        chk("mid_post_valid", 64'(ia_out.valid), 64'h0);

        chk("sb_empty", 64'(sb.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
